// File: rtl/cmp_sweep_checker.sv
// rtl/cmp_sweep_checker.sv - exhaustive 4-bit comparator sweep checker
// Optional first-fail operand capture is enabled by macro CMP_SWEEP_FIRST_FAIL_EN.
module cmp_sweep_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic       AgB,
  input  logic       AlB,
  input  logic       AeqB,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [3:0] fail_A,
  output logic [3:0] fail_B
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  logic [7:0] r_idx;
  logic [3:0] r_cnt;
  logic [8:0] r_err;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic [2:0] w_expected;
  logic [2:0] w_observed;
  logic       w_mismatch;
  logic [8:0] w_err_next;
  logic       w_start_ok;

  assign A = r_idx[7:4];
  assign B = r_idx[3:0];

  // Non-one-hot responses are caught because the whole triple is compared.
  assign w_expected = {(A > B), (A < B), (A == B)};
  assign w_observed = {AgB, AlB, AeqB};
  assign w_mismatch = (w_expected != w_observed);
  assign w_err_next = (w_mismatch && (r_err != 9'd256)) ? r_err + 9'd1 : r_err;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 8'd0;
      r_cnt   <= 4'd0;
      r_err   <= 9'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state <= S_SETTLE;
            r_idx   <= 8'd0;
            r_cnt   <= SETTLE_LAST;
            r_err   <= 9'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          r_err <= w_err_next;
          if (r_idx == 8'hFF) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 9'd0);
          end else begin
            r_state <= S_SETTLE;
            r_idx   <= r_idx + 8'd1;
            r_cnt   <= SETTLE_LAST;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

`ifdef CMP_SWEEP_FIRST_FAIL_EN
  logic       r_fail_seen;
  logic [3:0] r_fail_a;
  logic [3:0] r_fail_b;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_fail_seen <= 1'b0;
      r_fail_a    <= 4'd0;
      r_fail_b    <= 4'd0;
    end else if ((r_state == S_CHECK) && w_mismatch && !r_fail_seen) begin
      r_fail_seen <= 1'b1;
      r_fail_a    <= A;
      r_fail_b    <= B;
    end
  end

  assign fail_A = r_fail_a;
  assign fail_B = r_fail_b;
`else
  assign fail_A = 4'd0;
  assign fail_B = 4'd0;
`endif

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// tb/tb_cmp_sweep_checker.sv - directed bench for cmp_sweep_checker
// Fault-injecting comparator model; first-fail expectations follow CMP_SWEEP_FIRST_FAIL_EN.
module tb_cmp_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       AgB;
  logic       AlB;
  logic       AeqB;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [3:0] fail_A;
  logic [3:0] fail_B;

  int fault;
  int n_pass  = 0;
  int n_total = 0;

`ifdef CMP_SWEEP_FIRST_FAIL_EN
  localparam int FF_EN = 1;
`else
  localparam int FF_EN = 0;
`endif

  cmp_sweep_checker #(.SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .AgB       (AgB),
    .AlB       (AlB),
    .AeqB      (AeqB),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_A    (fail_A),
    .fail_B    (fail_B)
  );

  always #5 clk = ~clk;

  // Comparator under test: 0 good, 1 AgB stuck-0, 2 AgB/AlB swapped, 3 AeqB stuck-1
  always_comb begin
    AgB  = (A > B);
    AlB  = (A < B);
    AeqB = (A == B);
    case (fault)
      1: AgB = 1'b0;
      2: begin
        AgB = (A < B);
        AlB = (A > B);
      end
      3: AeqB = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic sweep(input int rp_idx, input int exp_err, input int exp_fa,
                       input int exp_fb, input string tag);
    int cyc;
    bit pulsed;
    cyc    = 0;
    pulsed = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy_first"}, busy, 1);
    check({tag, "_done_first"}, done, 0);
    check({tag, "_ab_first"}, {A, B}, 0);
    while (!done && cyc < 700) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (!pulsed && rp_idx >= 0 && {A, B} == rp_idx[7:0]) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc - 1, 512);
    check({tag, "_err"}, err_count, exp_err);
    check({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
    check({tag, "_fail_A"}, fail_A, exp_fa);
    check({tag, "_fail_B"}, fail_B, exp_fb);
    check({tag, "_ab_done"}, {A, B}, 8'hFF);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    int n;
    fault = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fail", {fail_A, fail_B}, 0);
    check("rst_ab", {A, B}, 0);
    rst = 1'b0;

    // rst and start on the same edge: reset wins
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_done", done, 0);

    sweep(-1, 0, 0, 0, "good");
    fault = 1;
    sweep(-1, 120, FF_EN, 0, "agb_stuck0");
    fault = 2;
    sweep(-1, 240, 0, FF_EN, "swap");
    fault = 3;
    sweep(-1, 240, 0, FF_EN, "aeqb_stuck1");

    // reset mid-sweep at idx=50 with a faulty comparator so err_count is nonzero
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ({A, B} != 8'd50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached50", {A, B}, 50);
    check("mid_err_nonzero", (err_count != 0) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_fail", {fail_A, fail_B}, 0);
    check("mid_rst_ab", {A, B}, 0);
    repeat (5) @(negedge clk);
    check("mid_no_resume", busy, 0);

    fault = 0;
    sweep(-1, 0, 0, 0, "after_rst");
    sweep(100, 0, 0, 0, "repulse");
    sweep(-1, 0, 0, 0, "restart_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
